// File: rtl/niosmp_pio_pkg.sv
// rtl/niosmp_pio_pkg.sv - shared constants for the Nios II PIO blocks
package niosmp_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_EDGE  = 0;
    localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/niosmp_pio_sync.sv
// rtl/niosmp_pio_sync.sv - width/stage parametrised input synchroniser, bypass at 0 stages
module niosmp_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = clk ^ reset_n;
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] chain [STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < STAGES; k++) chain[k] <= '0;
                end else begin
                    chain[0] <= d;
                    for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/niosmp_pio_in_irq.sv
// rtl/niosmp_pio_in_irq.sv - Avalon-MM input PIO with edge capture, irq mask and irq output
module niosmp_pio_in_irq
    import niosmp_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Arm gate needs to reach SYNC_STAGES+1 (up to 4), so it gets one spare bit.
    localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] ds, prev, mask, cap;
    logic [WIDTH-1:0] edge_raw, edge_vec, clr;
    logic [2:0]       arm_cnt;
    logic             armed, wr_en;
    logic [31:0]      rd_mux;
    logic             unused_ok;

    niosmp_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (ds)
    );

    assign unused_ok = ^writedata;
    assign armed     = (arm_cnt == ARM_DONE);
    assign wr_en     = chipselect & ~write_n;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_raw = ~ds & prev;
            EDGE_ANY:  edge_raw = ds ^ prev;
            default:   edge_raw = ds & ~prev;
        endcase
    end

    // Suppress the reset-to-input transition until the sync chain holds real data.
    assign edge_vec = armed ? edge_raw : '0;
    assign clr      = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = ds;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = cap;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            mask     <= '0;
            cap      <= '0;
            arm_cnt  <= '0;
            readdata <= '0;
        end else begin
            prev <= ds;
            if (!armed) arm_cnt <= arm_cnt + 3'd1;
            if (wr_en && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
            // Edge wins over a same-cycle clear so no event is lost.
            cap      <= (cap & ~clr) | edge_vec;
            readdata <= rd_mux;
        end
    end

    assign irq = (IRQ_MODE == IRQ_LEVEL) ? |(prev & mask) : |(cap & mask);

endmodule
